seg_scan_mux: RTL and testbench

Parametrised multi-channel seven-segment scanner for the board-level top of the single-cycle CPU. It replaces the fixed 8-digit, single-source display driver. It selects one of `NUM_CH` 32-bit-class debug words (PC, instruction, DMEM address/data, …) and snapshots it only at frame boundaries, so the display never tears. It then time-multiplexes `DIGITS` hex digits onto the common segment bus at a programmable scan rate.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_dec.sv | 11 +
 rtl/seg_scan_mux.sv | 106 ++++++++++
 tb/tb_seg_scan_mux.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment glyph constants and hex decode helper
package seg_pkg;

    localparam int NIB_W = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp always off
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex2seg(input logic [NIB_W-1:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// rtl/seg_hex_dec.sv - combinational nibble to active-low segment decoder
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [7:0]       seg
);

    assign seg = hex2seg(nib);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multi-channel frame-snapshot hex scanner; SEG_LZ_BLANK_EN enables leading-zero blanking
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int NUM_CH   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cs,
    input  logic [CH_W-1:0]              ch_sel,
    input  logic [NUM_CH*NIB_W*DIGITS-1:0] i_data,
    output logic [7:0]                   o_seg,
    output logic [DIGITS-1:0]            o_sel,
    output logic [CH_W-1:0]              o_ch
);

    localparam int W  = NIB_W * DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]     pcnt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic [W-1:0]      snap;
    logic [W-1:0]      cap_word;
    logic [W-1:0]      disp_word;
    logic [NIB_W-1:0]  nib;
    logic [7:0]        dec_seg;
    logic [DIGITS-1:0] sel_nx;
    logic              tick;
    logic              frame;
    logic              capture;
    logic              blank;

    assign tick     = (pcnt == PCNT_MAX);
    assign frame    = tick && (idx == IDX_LAST);
    assign capture  = frame && cs;
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Out-of-range channel selects fall through to an all-zero word
    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(ch_sel) == k) cap_word = i_data[k*W +: W];
        end
    end

    // Bypass so digit 0 of a new frame already shows the fresh capture
    assign disp_word = capture ? cap_word : snap;

    always_comb begin
        nib    = '0;
        sel_nx = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (int'(idx_next) == d) begin
                nib       = disp_word[d*NIB_W +: NIB_W];
                sel_nx[d] = 1'b0;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Blank when every nibble from this digit upward is zero; digit 0 always lit
    always_comb begin
        blank = (idx_next != '0);
        for (int d = 0; d < DIGITS; d++) begin
            if (d >= int'(idx_next) && disp_word[d*NIB_W +: NIB_W] != '0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    seg_hex_dec u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            idx   <= IDX_LAST;
            snap  <= '0;
            o_ch  <= '0;
            o_seg <= SEG_BLANK;
            o_sel <= '1;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx   <= idx_next;
                o_sel <= sel_nx;
                o_seg <= blank ? SEG_BLANK : dec_seg;
            end
            if (capture) begin
                snap <= cap_word;
                o_ch <= ch_sel;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux (DIGITS=4, NUM_CH=3, SCAN_DIV=2)
module tb_seg_scan_mux;

    localparam int DIGITS   = 4;
    localparam int NUM_CH   = 3;
    localparam int SCAN_DIV = 2;
    localparam int CH_W     = 2;

`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cs;
    logic [CH_W-1:0]   ch_sel;
    logic [15:0]       ch0, ch1, ch2;
    logic [47:0]       i_data;
    logic [7:0]        o_seg;
    logic [DIGITS-1:0] o_sel;
    logic [CH_W-1:0]   o_ch;

    int n_assert = 0;
    int n_fail   = 0;

    assign i_data = {ch2, ch1, ch0};

    always #5 clk = ~clk;

    seg_scan_mux #(
        .DIGITS   (DIGITS),
        .NUM_CH   (NUM_CH),
        .SCAN_DIV (SCAN_DIV),
        .CH_W     (CH_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs     (cs),
        .ch_sel (ch_sel),
        .i_data (i_data),
        .o_seg  (o_seg),
        .o_sel  (o_sel),
        .o_ch   (o_ch)
    );

    // Expected glyph built from an active-high gfedcba table, then inverted
    function automatic logic [7:0] g(input int n);
        logic [6:0] v;
        case (n)
            0:  v = 7'h3F;  1:  v = 7'h06;  2:  v = 7'h5B;  3:  v = 7'h4F;
            4:  v = 7'h66;  5:  v = 7'h6D;  6:  v = 7'h7D;  7:  v = 7'h07;
            8:  v = 7'h7F;  9:  v = 7'h6F;  10: v = 7'h77;  11: v = 7'h7C;
            12: v = 7'h39;  13: v = 7'h5E;  14: v = 7'h79;  default: v = 7'h71;
        endcase
        return {1'b1, ~v};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic dig(input string tag, input logic [3:0] sel, input logic [7:0] seg,
                       input logic [1:0] ch);
        check({tag, "_sel"}, {4'h0, o_sel}, {4'h0, sel});
        check({tag, "_seg"}, o_seg, seg);
        check({tag, "_ch"}, {6'h0, o_ch}, {6'h0, ch});
    endtask

    task automatic wait_tick();
        repeat (SCAN_DIV) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        cs     = 1'b1;
        ch_sel = 2'd1;
        ch0    = 16'h0000;
        ch1    = 16'h1234;
        ch2    = 16'hABCD;
        repeat (2) @(negedge clk);
        dig("reset", 4'hF, 8'hFF, 2'd0);

        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        dig("pre_tick", 4'hF, 8'hFF, 2'd0);
        @(posedge clk); @(negedge clk);
        dig("f1_d0", 4'hE, g(4), 2'd1);
        wait_tick(); dig("f1_d1", 4'hD, g(3), 2'd1);
        wait_tick(); dig("f1_d2", 4'hB, g(2), 2'd1);
        wait_tick(); dig("f1_d3", 4'h7, g(1), 2'd1);

        // Boundary with cs low while ch1 changes: snapshot holds
        cs  = 1'b0;
        ch1 = 16'hFFFF;
        wait_tick(); dig("hold_d0", 4'hE, g(4), 2'd1);
        cs  = 1'b1;
        ch1 = 16'h1234;
        wait_tick(); dig("hold_d1", 4'hD, g(3), 2'd1);
        wait_tick(); dig("hold_d2", 4'hB, g(2), 2'd1);
        wait_tick(); dig("hold_d3", 4'h7, g(1), 2'd1);

        // Mid-frame channel switch takes effect at the next boundary
        wait_tick(); dig("sw_d0", 4'hE, g(4), 2'd1);
        wait_tick(); dig("sw_d1", 4'hD, g(3), 2'd1);
        ch_sel = 2'd2;
        wait_tick(); dig("sw_d2", 4'hB, g(2), 2'd1);
        wait_tick(); dig("sw_d3", 4'h7, g(1), 2'd1);
        wait_tick(); dig("abcd_d0", 4'hE, g(13), 2'd2);
        wait_tick(); dig("abcd_d1", 4'hD, g(12), 2'd2);
        wait_tick(); dig("abcd_d2", 4'hB, g(11), 2'd2);
        wait_tick(); dig("abcd_d3", 4'h7, g(10), 2'd2);

        ch_sel = 2'd3;
        wait_tick(); dig("oor_d0", 4'hE, g(0), 2'd3);
        wait_tick(); dig("oor_d1", 4'hD, g(0), 2'd3);
        wait_tick(); dig("oor_d2", 4'hB, g(0), 2'd3);
        wait_tick(); dig("oor_d3", 4'h7, g(0), 2'd3);

        ch_sel = 2'd0;
        ch0    = 16'h0050;
        wait_tick(); dig("lz50_d0", 4'hE, g(0), 2'd0);
        wait_tick(); dig("lz50_d1", 4'hD, g(5), 2'd0);
        wait_tick(); dig("lz50_d2", 4'hB, LZ ? 8'hFF : g(0), 2'd0);
        wait_tick(); dig("lz50_d3", 4'h7, LZ ? 8'hFF : g(0), 2'd0);

        ch0 = 16'h0000;
        wait_tick(); dig("lz0_d0", 4'hE, g(0), 2'd0);
        wait_tick(); dig("lz0_d1", 4'hD, LZ ? 8'hFF : g(0), 2'd0);
        wait_tick(); dig("lz0_d2", 4'hB, LZ ? 8'hFF : g(0), 2'd0);
        wait_tick(); dig("lz0_d3", 4'h7, LZ ? 8'hFF : g(0), 2'd0);

        // Mid-frame asynchronous reset, then restart from the reset sequence
        ch_sel = 2'd1;
        wait_tick(); dig("pre_rst_d0", 4'hE, g(4), 2'd1);
        wait_tick(); dig("pre_rst_d1", 4'hD, g(3), 2'd1);
        rst_n = 1'b0;
        #1;
        dig("async_rst", 4'hF, 8'hFF, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        dig("re_pre_tick", 4'hF, 8'hFF, 2'd0);
        @(posedge clk); @(negedge clk);
        dig("re_d0", 4'hE, g(4), 2'd1);
        wait_tick(); dig("re_d1", 4'hD, g(3), 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
